// File: rtl/eint_filter.sv
// External-interrupt conditioner: debounces a synchronized pin, detects edges/levels
// per trig_mode, and latches a pending flag presented as a masked request.
module eint_filter #(
  parameter int DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_sync,
  input  logic [DEB_W-1:0] deb_len,
  input  logic [2:0]       trig_mode,
  input  logic             irq_en,
  input  logic             pend_clr,
  output logic             sig_filt,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             irq_pend,
  output logic             irq
);

  typedef enum logic {STABLE, FILTER} state_t;

  state_t           state, state_n;
  logic [DEB_W-1:0] cnt, cnt_n;
  logic [DEB_W:0]   cnt_inc;
  logic [DEB_W:0]   len_eff;
  logic             mismatch;
  logic             upd;
  logic             set;

  // Compare at DEB_W+1 bits so a full-scale deb_len never wraps the count.
  assign cnt_inc  = {1'b0, cnt} + {{DEB_W{1'b0}}, 1'b1};
  assign len_eff  = (deb_len == '0) ? {{DEB_W{1'b0}}, 1'b1} : {1'b0, deb_len};
  assign mismatch = (sig_sync != sig_filt);
  assign upd      = mismatch && (cnt_inc >= len_eff);

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      STABLE: begin
        if (mismatch && !upd) begin
          state_n = FILTER;
          cnt_n   = cnt_inc[DEB_W-1:0];
        end else begin
          state_n = STABLE;
        end
      end
      FILTER: begin
        if (!mismatch || upd) begin
          state_n = STABLE;
        end else begin
          cnt_n = cnt_inc[DEB_W-1:0];
        end
      end
      default: state_n = STABLE;
    endcase
  end

  always_comb begin
    set = 1'b0;
    case (trig_mode)
      3'd0:    set = edge_rise;
      3'd1:    set = edge_fall;
      3'd2:    set = edge_rise | edge_fall;
      3'd3:    set = sig_filt;
      3'd4:    set = ~sig_filt;
      default: set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STABLE;
      cnt       <= '0;
      sig_filt  <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
      irq_pend  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if (upd) sig_filt <= sig_sync;
      edge_rise <= upd & sig_sync;
      edge_fall <= upd & ~sig_sync;
      // Set beats clear so an event coinciding with a clear is not lost.
      irq_pend  <= set | (irq_pend & ~pend_clr);
    end
  end

  assign irq = irq_pend & irq_en;

endmodule

// File: tb/tb_eint_filter.sv
// Directed, table-driven bench for eint_filter plus hand sequences for reset and limits.
module tb_eint_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_sync;
  logic [7:0] deb_len;
  logic [2:0] trig_mode;
  logic       irq_en;
  logic       pend_clr;
  logic       sig_filt, edge_rise, edge_fall, irq_pend, irq;

  int tests = 0;
  int fails = 0;

  eint_filter #(.DEB_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_sync  (sig_sync),
    .deb_len   (deb_len),
    .trig_mode (trig_mode),
    .irq_en    (irq_en),
    .pend_clr  (pend_clr),
    .sig_filt  (sig_filt),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall),
    .irq_pend  (irq_pend),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sig;
    logic       clr;
    logic       en;
    logic [2:0] trig;
    logic [7:0] len;
    logic [4:0] exp;   // {filt, rise, fall, pend, irq}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic c, logic e, logic [2:0] t, logic [7:0] l,
                              logic [4:0] x);
    vec_t v;
    v.sig = s; v.clr = c; v.en = e; v.trig = t; v.len = l; v.exp = x;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {sig_filt, edge_rise, edge_fall, irq_pend, irq};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (filt,rise,fall,pend,irq)", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sig_sync = 1'b0; deb_len = 8'd4; trig_mode = 3'd0;
    irq_en = 1'b1; pend_clr = 1'b0;

    // Rising-edge latency, deb_len=4, trig rising
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b11000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b10011));
    vecs.push_back(mk(1, 1, 1, 0, 4, 5'b10000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b10000));
    // Return low; falling edge does not set in rising mode
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b10000));
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b10000));
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b10000));
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b00100));
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b00000));
    // Glitch: high 3, low 1, high 4
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(0, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b00000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b11000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b10011));
    vecs.push_back(mk(1, 1, 1, 0, 4, 5'b10000));
    vecs.push_back(mk(1, 0, 1, 0, 4, 5'b10000));
    // Level-high mode, deb_len=0 acts as 1; clear while level active is ignored
    vecs.push_back(mk(1, 0, 1, 3, 0, 5'b10011));
    vecs.push_back(mk(1, 1, 1, 3, 0, 5'b10011));
    vecs.push_back(mk(0, 0, 1, 3, 0, 5'b00111));
    vecs.push_back(mk(0, 0, 1, 3, 0, 5'b00011));
    vecs.push_back(mk(0, 1, 1, 3, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 1, 3, 0, 5'b00000));
    // Both-edge mode masked; clear collides with edge_fall
    vecs.push_back(mk(1, 0, 0, 2, 1, 5'b11000));
    vecs.push_back(mk(1, 0, 0, 2, 1, 5'b10010));
    vecs.push_back(mk(1, 1, 0, 2, 1, 5'b10000));
    vecs.push_back(mk(0, 0, 0, 2, 1, 5'b00100));
    vecs.push_back(mk(0, 1, 0, 2, 1, 5'b00010));

    #12;
    chk("reset_state", outs(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", outs(), 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      sig_sync = vecs[i].sig; pend_clr = vecs[i].clr; irq_en = vecs[i].en;
      trig_mode = vecs[i].trig; deb_len = vecs[i].len;
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Enabling the mask raises irq combinationally
    pend_clr = 1'b0;
    irq_en = 1'b1;
    #1;
    chk("mask_enable_same_cycle", outs(), 5'b00011);

    // Reset mid-count with pending flag set
    trig_mode = 3'd0; deb_len = 8'd8; sig_sync = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("midcount_before_reset", outs(), 5'b00011);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 5'b00000);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) chk("after_reset_edge7", outs(), 5'b00000);
      if (i == 8) chk("after_reset_edge8", outs(), 5'b11000);
    end

    // Disabled trig_mode with clear; then deb_len=255 full-scale count
    trig_mode = 3'd6; pend_clr = 1'b1;
    step();
    chk("mode6_after_rise", outs(), 5'b10000);
    pend_clr = 1'b0; deb_len = 8'd255; sig_sync = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i == 1)   chk("len255_edge1", outs(), 5'b10000);
      if (i == 254) chk("len255_edge254", outs(), 5'b10000);
      if (i == 255) chk("len255_edge255", outs(), 5'b00100);
    end

    // Mode 6: toggling input never sets pending
    deb_len = 8'd1;
    for (int i = 0; i < 6; i++) begin
      sig_sync = ~sig_sync;
      step();
      chk($sformatf("mode6_toggle%0d", i), {edge_rise | edge_fall, irq_pend, irq}, 3'b100);
      step();
      chk($sformatf("mode6_hold%0d", i), {irq_pend, irq}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
